// File: rtl/pheap_pq_arbiter_if.sv
// Device-side bus of one pheap_pq instance. The arbiter drives it as master,
// and the priority queue answers as slave.
interface pheap_pq_arbiter_if #(
    parameter int KVW = 16
);
    logic           enq;
    logic           deq;
    logic [KVW-1:0] kvi;
    logic [KVW-1:0] kvo;
    logic           full;
    logic           empty;
    logic           busy;

    modport master (output enq, deq, kvi, input kvo, full, empty, busy);
    modport slave  (input enq, deq, kvi, output kvo, full, empty, busy);
endinterface

// File: rtl/pheap_pq_arbiter.sv
// Round-robin arbiter that shares one pheap_pq among NREQ requesters. It issues one
// gated operation at a time and returns the removed head to the requester that issued the dequeue.
module pheap_pq_arbiter #(
    parameter int             NREQ     = 4,
    parameter int             GAP      = 2,
    parameter int             KVW      = 16,
    parameter logic [KVW-1:0] KV_EMPTY = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_enq,
    input  logic [NREQ-1:0]           req_deq,
    input  logic [NREQ-1:0][KVW-1:0]  req_kvi,
    output logic [NREQ-1:0]           req_ack,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [KVW-1:0]            rsp_kvo,
    output logic [15:0]               stall_cnt,
    pheap_pq_arbiter_if.master        pq
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t          state, stateNext;
    logic [RW-1:0]   rr, rrNext;
    logic [CW-1:0]   holdCnt, holdCntNext;
    logic [NREQ-1:0] ackNext, validNext;
    logic [KVW-1:0]  rspKvoNext, pqKviNext;
    logic            pqEnqNext, pqDeqNext;
    logic [15:0]     stallNext;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pending;
    logic            found;
    logic [RW-1:0]   winner;
    logic [RW-1:0]   cand;

    // Any request that removes the head (plain deq or replace) needs a non-empty queue.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pending[i]  = req_enq[i] | req_deq[i];
            eligible[i] = req_deq[i] ? !pq.empty : (req_enq[i] & !pq.full);
        end
    end

    // First eligible requester at or after rr; ineligible ones are simply skipped.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = RW'((int'(rr) + k) % NREQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        rrNext      = rr;
        holdCntNext = holdCnt;
        ackNext     = '0;
        validNext   = '0;
        rspKvoNext  = KV_EMPTY;
        pqEnqNext   = 1'b0;
        pqDeqNext   = 1'b0;
        pqKviNext   = KV_EMPTY;
        stallNext   = stall_cnt;
        case (state)
            IDLE: begin
                if (!pq.busy && found) begin
                    pqEnqNext       = req_enq[winner];
                    pqDeqNext       = req_deq[winner];
                    pqKviNext       = req_kvi[winner];
                    ackNext[winner] = 1'b1;
                    if (req_deq[winner]) begin
                        validNext[winner] = 1'b1;
                        rspKvoNext        = pq.kvo;
                    end
                    rrNext      = RW'((int'(winner) + 1) % NREQ);
                    holdCntNext = CW'(GAP);
                    stateNext   = HOLD;
                end else if (|pending && stall_cnt != 16'hFFFF) begin
                    stallNext = stall_cnt + 16'd1;
                end
            end
            // Busy may rise a cycle after the issue, so it is not looked at until GAP has elapsed.
            HOLD: begin
                holdCntNext = holdCnt - CW'(1);
                if (holdCnt <= CW'(1)) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (!pq.busy) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            holdCnt   <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_kvo   <= KV_EMPTY;
            pq.enq    <= 1'b0;
            pq.deq    <= 1'b0;
            pq.kvi    <= KV_EMPTY;
            stall_cnt <= '0;
        end else begin
            state     <= stateNext;
            rr        <= rrNext;
            holdCnt   <= holdCntNext;
            req_ack   <= ackNext;
            rsp_valid <= validNext;
            rsp_kvo   <= rspKvoNext;
            pq.enq    <= pqEnqNext;
            pq.deq    <= pqDeqNext;
            pq.kvi    <= pqKviNext;
            stall_cnt <= stallNext;
        end
    end
endmodule

// File: tb/tb_pheap_pq_arbiter.sv
// Bench for pheap_pq_arbiter: a behavioural priority-queue device, per-requester expectation
// queues and a negedge monitor that checks every ack against a reference multiset.
module tb_pheap_pq_arbiter;
    localparam int          NREQ     = 4;
    localparam int          GAP      = 2;
    localparam int          KVW      = 16;
    localparam int          CAP      = 4;
    localparam logic [15:0] KV_EMPTY = 16'hFFFF;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_enq = '0;
    logic [NREQ-1:0]       req_deq = '0;
    logic [NREQ-1:0][15:0] req_kvi = '0;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [15:0]           rsp_kvo;
    logic [15:0]           stall_cnt;

    pheap_pq_arbiter_if #(.KVW(KVW)) pqBus();

    pheap_pq_arbiter #(.NREQ(NREQ), .GAP(GAP), .KVW(KVW), .KV_EMPTY(KV_EMPTY)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_enq   (req_enq),
        .req_deq   (req_deq),
        .req_kvi   (req_kvi),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_kvo   (rsp_kvo),
        .stall_cnt (stall_cnt),
        .pq        (pqBus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Device: sorted contents, head is the minimum, busy rises one cycle after the op for 1..4 cycles.
    logic [15:0] devQ[$];
    int          busyCnt = 0;
    int          busyLen = 0;
    logic        busyLate = 1'b0;
    logic        forceBusy = 1'b0;
    assign pqBus.busy = forceBusy | (busyCnt > 0);

    always @(posedge clk) begin
        if (pqBus.enq || pqBus.deq) begin
            if (pqBus.deq && devQ.size() > 0) void'(devQ.pop_front());
            if (pqBus.enq && devQ.size() < CAP) devQ.push_back(pqBus.kvi);
            devQ.sort();
            busyLate <= 1'b1;
            busyLen  <= int'($urandom_range(1, 4));
        end else begin
            busyLate <= 1'b0;
        end
        if (busyLate) busyCnt <= busyLen;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
        pqBus.kvo   <= (devQ.size() > 0) ? devQ[0] : KV_EMPTY;
        pqBus.full  <= (devQ.size() == CAP);
        pqBus.empty <= (devQ.size() == 0);
    end

    function automatic bit refEligible(input logic e, input logic d, input int size);
        if (d) return size > 0;
        if (e) return size < CAP;
        return 1'b0;
    endfunction

    logic [17:0]     expQ [NREQ][$];
    logic [15:0]     refQ[$];
    logic [NREQ-1:0] prevEnq = '0;
    logic [NREQ-1:0] prevDeq = '0;
    int              prevSize = 0;
    int              lastW = NREQ - 1;
    int              sinceAck = 1000;
    int              enqPulses = 0;
    int              mW, mExpW;
    logic [17:0]     mE;
    logic [15:0]     mHead;

    always @(negedge clk) begin
        if (rst) begin
            lastW    = NREQ - 1;
            sinceAck = 1000;
        end else begin
            sinceAck++;
            if (pqBus.enq) enqPulses++;
            if (req_ack == '0) begin
                checkOutput("no op without ack", 32'({pqBus.enq, pqBus.deq, |rsp_valid}), 0);
            end else begin
                checkOutput("ack one-hot", 32'($onehot(req_ack)), 1);
                mW = 0;
                for (int i = 0; i < NREQ; i++) if (req_ack[i]) mW = i;
                mExpW = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (mExpW < 0 && refEligible(prevEnq[(lastW + k) % NREQ], prevDeq[(lastW + k) % NREQ], prevSize))
                        mExpW = (lastW + k) % NREQ;
                end
                checkOutput("round-robin winner", mW, mExpW);
                checkOutput("issue spacing", 32'(sinceAck >= GAP + 2), 1);
                sinceAck = 0;
                checkOutput("acked requester had a request", 32'(expQ[mW].size() > 0), 1);
                if (expQ[mW].size() > 0) begin
                    mE = expQ[mW].pop_front();
                    checkOutput("op class", 32'({pqBus.enq, pqBus.deq}), 32'(mE[17:16]));
                    if (mE[17]) checkOutput("pq_kvi", pqBus.kvi, mE[15:0]);
                    checkOutput("rsp_valid", rsp_valid, mE[16] ? req_ack : '0);
                    if (mE[16]) begin
                        mHead = (refQ.size() > 0) ? refQ[0] : KV_EMPTY;
                        checkOutput("rsp_kvo", rsp_kvo, mHead);
                        if (refQ.size() > 0) void'(refQ.pop_front());
                    end
                    if (mE[17] && refQ.size() < CAP) refQ.push_back(pqBus.kvi);
                    refQ.sort();
                end
                lastW = mW;
            end
        end
        prevEnq  = req_enq;
        prevDeq  = req_deq;
        prevSize = refQ.size();
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int i, input logic e, input logic d, input logic [15:0] kv,
                                 input int budget, output int lat);
        req_kvi[i] = kv;
        req_enq[i] = e;
        req_deq[i] = d;
        expQ[i].push_back({e, d, kv});
        lat = 0;
        while (!req_ack[i] && lat < budget) begin
            @(posedge clk);
            #2;
            lat++;
        end
        checkOutput($sformatf("ack for req%0d within budget", i), 32'(req_ack[i]), 1);
        if (!req_ack[i]) void'(expQ[i].pop_back());
        req_enq[i] = 1'b0;
        req_deq[i] = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ack"}, req_ack, 0);
        checkOutput({tag, " rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, " rsp_kvo"}, rsp_kvo, KV_EMPTY);
        checkOutput({tag, " pq enq/deq"}, 32'({pqBus.enq, pqBus.deq}), 0);
        checkOutput({tag, " pq_kvi"}, pqBus.kvi, KV_EMPTY);
        checkOutput({tag, " stall_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    int          age [NREQ];
    logic [1:0]  rCls;

    initial begin
        int l0, l1, l2, l3, s0, p0;
        idle(3);
        checkResetOutputs("reset");
        rst = 1'b0;
        idle(2);

        // Single requester enqueue then dequeue.
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 20, l0);
        checkOutput("T1 enq latency", l0, 1);
        idle(12);
        applyStimulus(0, 1'b0, 1'b1, 16'h0000, 20, l0);
        checkOutput("T1 deq latency", l0, 1);
        idle(12);
        checkOutput("T1 queue empty again", 32'(pqBus.empty), 1);

        // From reset, four simultaneous enqueues served in index order.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        p0 = enqPulses;
        fork
            applyStimulus(0, 1'b1, 1'b0, 16'h0004, 80, l0);
            applyStimulus(1, 1'b1, 1'b0, 16'h0003, 80, l1);
            applyStimulus(2, 1'b1, 1'b0, 16'h0002, 80, l2);
            applyStimulus(3, 1'b1, 1'b0, 16'h0001, 80, l3);
        join
        idle(12);
        checkOutput("T2 enq pulses", enqPulses - p0, 4);
        checkOutput("T2 first ack latency", l0, 1);
        checkOutput("T2 ack order", 32'(l0 < l1 && l1 < l2 && l2 < l3), 1);
        checkOutput("T2 queue full", 32'(pqBus.full), 1);

        // Full queue: blocked enqueue must not starve a later dequeue.
        s0 = stall_cnt;
        fork
            applyStimulus(0, 1'b1, 1'b0, 16'h0055, 80, l0);
            begin
                idle(5);
                applyStimulus(2, 1'b0, 1'b1, 16'h0000, 80, l2);
            end
        join
        idle(12);
        checkOutput("T3 deq latency", l2, 1);
        checkOutput("T3 enq served after deq", 32'(l0 > 6), 1);
        checkOutput("T3 stall delta", stall_cnt - 16'(s0), 5);

        // Drain, then replace on empty waits for another requester's enqueue.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1, 1'b0, 1'b1, 16'h0000, 40, l1);
            idle(12);
        end
        checkOutput("T4 drained", 32'(pqBus.empty), 1);
        fork
            applyStimulus(1, 1'b1, 1'b1, 16'h0020, 80, l1);
            applyStimulus(3, 1'b1, 1'b0, 16'h0030, 80, l3);
        join
        idle(12);
        checkOutput("T4 enq latency", l3, 1);
        checkOutput("T4 replace after enq", 32'(l1 > l3), 1);

        // Busy held for 10 cycles blocks issue; issue follows one cycle after it drops.
        forceBusy = 1'b1;
        fork
            applyStimulus(2, 1'b1, 1'b0, 16'h0044, 40, l2);
            begin
                idle(10);
                forceBusy = 1'b0;
            end
        join
        checkOutput("T5 latency under busy", l2, 11);
        idle(12);

        // Reset while waiting on busy; pending requests restart from requester 0.
        applyStimulus(2, 1'b1, 1'b0, 16'h0040, 20, l2);
        forceBusy = 1'b1;
        idle(4);
        fork
            applyStimulus(1, 1'b0, 1'b1, 16'h0000, 80, l1);
            applyStimulus(3, 1'b0, 1'b1, 16'h0000, 80, l3);
            begin
                idle(2);
                rst = 1'b1;
                idle(1);
                checkResetOutputs("T6 reset in WAIT");
                rst = 1'b0;
                idle(2);
                forceBusy = 1'b0;
            end
        join
        checkOutput("T6 req1 served before req3", 32'(l1 < l3), 1);
        idle(12);

        // Randomized traffic with abandonment of requests that wait too long.
        for (int i = 0; i < NREQ; i++) age[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_enq[i] | req_deq[i]) begin
                    if (req_ack[i]) begin
                        req_enq[i] = 1'b0;
                        req_deq[i] = 1'b0;
                    end else if (age[i] > 40) begin
                        req_enq[i] = 1'b0;
                        req_deq[i] = 1'b0;
                        void'(expQ[i].pop_back());
                    end else begin
                        age[i]++;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rCls       = 2'($urandom_range(1, 3));
                    req_kvi[i] = 16'($urandom);
                    req_enq[i] = rCls[1];
                    req_deq[i] = rCls[0];
                    expQ[i].push_back({rCls, req_kvi[i]});
                    age[i] = 0;
                end
            end
            idle(1);
        end
        for (int i = 0; i < NREQ; i++) begin
            if ((req_enq[i] | req_deq[i]) && !req_ack[i]) void'(expQ[i].pop_back());
            req_enq[i] = 1'b0;
            req_deq[i] = 1'b0;
        end
        idle(20);
        checkOutput("final queue size", devQ.size(), refQ.size());
        for (int i = 0; i < NREQ; i++)
            checkOutput($sformatf("req%0d expectations consumed", i), expQ[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
